// File: rtl/audio_recorder.sv
// audio_recorder: captures 16-bit I2S samples from the WM8731 ADC serial
// output and issues one SRAM write per sample at incrementing addresses.
//
// Optional feature macro: AUDREC_STEREO_EN
//   undefined : left channel only, LRC rising edges are ignored.
//   defined   : left and right channels are captured and written to
//               consecutive addresses; pause/stop act on frame boundaries.
//
// Timing reference: cycle t is the first bit-clock cycle in which the ADC
// LR clock is seen low after being high. The MSB is on i_data in cycle t+1
// and the LSB in cycle t+16. The write strobe is high in cycle t+17.

module audio_recorder #(
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [15:0]       o_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_length,
    output logic              o_finished
);

`ifdef AUDREC_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SKIP,
        S_SHIFT,
        S_STORE,
        S_PAUSED,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                lrc_prev_q;
    logic [15:0]         shreg_q;
    logic [3:0]          bit_cnt_q;
    logic                pause_pend_q;
    logic                stop_pend_q;
    logic                chan_q;
    logic                last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   o_address_q;
    logic [15:0]         o_data_q;
    logic                o_valid_q;
    logic [ADDR_W-1:0]   o_length_q;
    logic                o_finished_q;

    logic                lrc_fall_d;
    logic                lrc_rise_d;
    logic                chan_edge_d;
    logic [15:0]         sample_d;
    logic                frame_end_d;
    logic                wait_pause_d;

    // Edge detection on LRC, the next shifted sample and frame-boundary helpers
    always_comb begin
        lrc_fall_d   = lrc_prev_q & ~i_lrc;
        lrc_rise_d   = ~lrc_prev_q & i_lrc;
        chan_edge_d  = (STEREO && chan_q) ? lrc_rise_d : lrc_fall_d;
        sample_d     = {shreg_q[14:0], i_data};
        frame_end_d  = !STEREO || chan_q;
        wait_pause_d = i_pause && !(STEREO && chan_q);
    end

    // Capture FSM with all outputs registered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            lrc_prev_q   <= 1'b0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            pause_pend_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            chan_q       <= 1'b0;
            last_q       <= 1'b0;
            addr_q       <= '0;
            o_address_q  <= '0;
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
            o_length_q   <= '0;
            o_finished_q <= 1'b0;
        end else begin
            lrc_prev_q <= i_lrc;
            o_valid_q  <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (!i_stop && !i_pause && i_start) begin
                        addr_q       <= '0;
                        o_length_q   <= '0;
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        chan_q       <= 1'b0;
                        last_q       <= 1'b0;
                        o_finished_q <= 1'b0;
                        state_q      <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_stop) begin
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (wait_pause_d) begin
                        pause_pend_q <= 1'b0;
                        state_q      <= S_PAUSED;
                    end else begin
                        if (i_pause) begin
                            pause_pend_q <= 1'b1;
                        end
                        if (chan_edge_d) begin
                            state_q <= S_SKIP;
                        end
                    end
                end

                S_SKIP: begin
                    if (i_stop && !STEREO) begin
                        pause_pend_q <= 1'b0;
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        if (i_stop) begin
                            stop_pend_q <= 1'b1;
                        end
                        if (i_pause) begin
                            pause_pend_q <= 1'b1;
                        end
                        shreg_q   <= sample_d;
                        bit_cnt_q <= 4'd1;
                        state_q   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (i_stop && !STEREO) begin
                        pause_pend_q <= 1'b0;
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        if (i_stop) begin
                            stop_pend_q <= 1'b1;
                        end
                        if (i_pause) begin
                            pause_pend_q <= 1'b1;
                        end
                        shreg_q   <= sample_d;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            o_valid_q   <= 1'b1;
                            o_data_q    <= sample_d;
                            o_address_q <= addr_q;
                            o_length_q  <= o_length_q + ONE;
                            last_q      <= (addr_q == ADDR_MAX);
                            if (addr_q != ADDR_MAX) begin
                                addr_q <= addr_q + ONE;
                            end
                            state_q <= S_STORE;
                        end
                    end
                end

                S_STORE: begin
                    chan_q <= STEREO && !chan_q;
                    if (last_q) begin
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (frame_end_d && (stop_pend_q || (STEREO && i_stop))) begin
                        pause_pend_q <= 1'b0;
                        stop_pend_q  <= 1'b0;
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (frame_end_d && (pause_pend_q || i_pause)) begin
                        pause_pend_q <= 1'b0;
                        state_q      <= S_PAUSED;
                    end else begin
                        if (i_pause) begin
                            pause_pend_q <= 1'b1;
                        end
                        if (STEREO && i_stop) begin
                            stop_pend_q <= 1'b1;
                        end
                        state_q <= S_WAIT;
                    end
                end

                S_PAUSED: begin
                    chan_q <= 1'b0;
                    if (i_stop) begin
                        o_finished_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (!i_pause && i_start) begin
                        state_q <= S_WAIT;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_address  = o_address_q;
    assign o_data     = o_data_q;
    assign o_valid    = o_valid_q;
    assign o_length   = o_length_q;
    assign o_finished = o_finished_q;

endmodule

// File: doc/audio_recorder.md
# audio_recorder

- Captures 16-bit I2S samples from the WM8731 ADC serial output and issues one SRAM write per sample, at incrementing word addresses.
- Sits downstream of the codec I2C initialization stage. The top level starts it only after that stage reports finished.
- Its write address and sample count feed the SRAM arbiter and the playback block.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width.
- ADDR_MAX, 20'hFFFFF, last writable address. Recording ends after a write to it.

Ports:
- i_clk  in  1  codec bit clock (AUD_BCLK); all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lrc  in  1  ADC LR clock (AUD_ADCLRCK); low = left channel.
- i_data  in  1  ADC serial data (AUD_ADCDAT), MSB first.
- i_start  in  1  start new recording, or resume from pause; level-sampled.
- i_pause  in  1  pause request; level-sampled.
- i_stop  in  1  stop request; level-sampled.
- o_address  out  ADDR_W  SRAM write address.
- o_data  out  16  sample to write.
- o_valid  out  1  one-cycle write strobe.
- o_length  out  ADDR_W  number of samples written in the current/last recording.
- o_finished  out  1  high in S_DONE.

## Operation
States:
- S_IDLE, S_WAIT, S_SKIP, S_SHIFT, S_STORE, S_PAUSED, S_DONE.

Edge detection:
- lrc_prev is a register of i_lrc, reset value 0.
- Falling edge = lrc_prev==1 && i_lrc==0.

Command priority each cycle: i_stop > i_pause > i_start.

Transitions:
- S_IDLE / S_DONE, i_start=1:
  - address counter=0, o_length=0, go S_WAIT.
- S_WAIT, LRC falling edge: go S_SKIP. This cycle is t.
- S_SKIP: go S_SHIFT. This is the I2S one-bit delay.
- S_SHIFT:
  - Shift i_data into shreg each cycle, bit 15 at t+1 down to bit 0 at t+16.
  - After 16 bits, go S_STORE.
- S_STORE:
  - o_valid=1, o_data=shreg, o_address=current address.
  - Address counter += 1, o_length += 1.
  - If address == ADDR_MAX: go S_DONE.
  - Else if pause pending: go S_PAUSED.
  - Else: go S_WAIT.
- S_PAUSED: i_start=1 → S_WAIT; address and length are kept.

i_stop:
- In S_WAIT, S_SKIP, S_SHIFT or S_PAUSED: go S_DONE next cycle.
- A partially shifted sample is discarded and never written.

i_pause:
- In S_WAIT: go S_PAUSED immediately.
- In S_SKIP or S_SHIFT: latch pending. The current sample completes and is written, then S_PAUSED.

Other rules:
- LRC edges seen during S_SKIP/S_SHIFT/S_STORE are ignored. A frame must give at least 18 cycles per channel.
- i_start in S_WAIT/S_SKIP/S_SHIFT/S_STORE is ignored.
- The address counter never wraps: S_DONE is entered on the write to ADDR_MAX.

## Timing
Reset values:
- o_address=0, o_data=0, o_valid=0, o_length=0, o_finished=0.
- State S_IDLE, shreg=0, pause-pending=0, lrc_prev=0.

Sample timing:
- Latency: LRC falling edge at cycle t → o_valid high in cycle t+17, exactly one cycle.
- o_data and o_address are stable while o_valid=1. They hold their values until the next write.

Outputs:
- o_finished is registered: high starting the cycle after S_DONE is entered, until i_start.
- o_length updates in the same cycle as the o_valid strobe. It holds the count after S_DONE.

Reset:
- Asynchronous reset mid-capture: all outputs return to reset values immediately.
- No write is issued for the interrupted sample.

## Configuration
- AUDREC_STEREO_EN defined:
  - The right channel is also captured, starting at the LRC rising edge with the same S_SKIP/S_SHIFT/S_STORE timing.
  - Each channel is written to its own consecutive address: left at address n, right at n+1.
  - Pause and stop take effect only after the right sample is stored (frame boundary), except i_stop in S_WAIT/S_PAUSED.
  - If ADDR_MAX is reached on the left write, the right sample is not written.
- Undefined:
  - Left channel only; LRC rising edges are ignored.

## Test plan
- Reset, start, 32-cycle-per-channel frames with left sample 16'hA5C3:
  - o_valid at t+17, o_data=16'hA5C3, o_address=0.
  - Next frame's write at address 1, o_length=2 after two frames.
- ADDR_MAX=20'h3, continuous frames:
  - Exactly 4 writes (addresses 0..3).
  - o_finished=1 from the cycle after the 4th write; o_length=4.
- i_pause asserted at t+8 of the third sample:
  - Sample written at address 2, then S_PAUSED with no writes for 5 frames.
  - i_start resumes; next write at address 3.
- i_stop at t+10:
  - No write for that sample; o_finished=1 next cycle.
  - A following i_start restarts at address 0 with o_length=0.
- Reset asserted at t+12:
  - All outputs 0 immediately, no o_valid.
  - After release and i_start, the first write is at address 0.
- AUDREC_STEREO_EN, left 16'h1234 / right 16'hFEDC:
  - Writes at addresses 0 and 1 with those values, 32 cycles apart.
